systolic_mm_engine: RTL and testbench

SYSTOLIC_MM_ENGINE -- requirements
Module: systolic_mm_engine

---
 rtl/systolic_mm_engine.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: output-stationary ROWS x COLS systolic matrix multiplier.
// Each operand beat carries one column of A and one row of B.
// The array accumulates C = A*B in place. Result rows are then read out one
// per valid/ready handshake.
// Optional feature macro: SA_SATURATE_EN.
//   Defined:   each accumulate saturates to the signed ACC_W range.
//   Undefined: each accumulate wraps modulo 2^ACC_W.
module systolic_mm_engine #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int A_W   = 16,
    parameter int B_W   = 16,
    parameter int ACC_W = 40,
    parameter int K_MAX = 256,
    localparam int KW   = $clog2(K_MAX + 1),
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [KW-1:0]          i_k_len,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [ROWS*A_W-1:0]    i_a,
    input  logic [COLS*B_W-1:0]    i_b,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_res_valid,
    input  logic                   i_res_ready,
    output logic [COLS*ACC_W-1:0]  o_res_data,
    output logic [RW-1:0]          o_res_row
);

    // Widths: full product, and a sum wide enough never to overflow before range checks.
    localparam int PW      = A_W + B_W;
    localparam int SW      = ((ACC_W > PW) ? ACC_W : PW) + 1;
    // After the last beat, ROWS+COLS-1 zero cycles let it reach the far corner PE.
    localparam int FLUSH_N = ROWS + COLS - 1;
    localparam int FW      = $clog2(FLUSH_N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_len_q, k_len_d;
    logic [KW-1:0] beat_q, beat_d;
    logic [FW-1:0] flush_q, flush_d;
    logic [RW-1:0] row_q, row_d;

    logic          clr;
    logic          adv;
    logic          accept;
    logic [KW-1:0] k_req;

    // Skewed operands entering the west / north edges, and the per-PE pipeline taps.
    logic signed [A_W-1:0]   a_edge [ROWS];
    logic signed [B_W-1:0]   b_edge [COLS];
    logic signed [A_W-1:0]   a_fwd  [ROWS][COLS];
    logic signed [B_W-1:0]   b_fwd  [ROWS][COLS];
    logic signed [ACC_W-1:0] acc    [ROWS][COLS];

    // Job-level strobes: clear on start, advance the array in LOAD/FLUSH, beat acceptance.
    always_comb begin
        clr    = (state_q == S_IDLE) && i_start;
        adv    = (state_q == S_LOAD) || (state_q == S_FLUSH);
        accept = (state_q == S_LOAD) && i_in_valid;
        k_req  = (i_k_len > KW'(K_MAX)) ? KW'(K_MAX) : i_k_len;
    end

    // Next-state and counter logic for the job sequencer.
    always_comb begin
        state_d = state_q;
        k_len_d = k_len_q;
        beat_d  = beat_q;
        flush_d = flush_q;
        row_d   = row_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    k_len_d = k_req;
                    beat_d  = '0;
                    flush_d = '0;
                    row_d   = '0;
                    state_d = (k_req == '0) ? S_DRAIN : S_LOAD;
                end
            end
            S_LOAD: begin
                if (i_in_valid) begin
                    beat_d = beat_q + KW'(1);
                    if (beat_q + KW'(1) == k_len_q) begin
                        state_d = S_FLUSH;
                        flush_d = '0;
                    end
                end
            end
            S_FLUSH: begin
                flush_d = flush_q + FW'(1);
                if (flush_q == FW'(FLUSH_N - 1)) begin
                    state_d = S_DRAIN;
                    row_d   = '0;
                end
            end
            S_DRAIN: begin
                if (i_res_ready) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset aborts any job in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_len_q <= '0;
            beat_q  <= '0;
            flush_q <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            k_len_q <= k_len_d;
            beat_q  <= beat_d;
            flush_q <= flush_d;
            row_q   <= row_d;
        end
    end

    // Status outputs decode directly from the state.
    always_comb begin
        o_busy      = (state_q != S_IDLE);
        o_in_ready  = (state_q == S_LOAD);
        o_done      = (state_q == S_DONE);
        o_res_valid = (state_q == S_DRAIN);
        o_res_row   = o_res_valid ? row_q : '0;
    end

    genvar gi, gj;

    // Result row mux; outputs read zero when no row is being presented.
    for (gi = 0; gi < COLS; gi++) begin : g_res
        assign o_res_data[gi*ACC_W +: ACC_W] = o_res_valid ? acc[row_q][gi] : '0;
    end

    // A skew: lane r is delayed r cycles so it meets the matching B lane in each PE.
    for (gi = 0; gi < ROWS; gi++) begin : g_a_skew
        logic signed [A_W-1:0] inj;
        assign inj = accept ? i_a[gi*A_W +: A_W] : '0;
        if (gi == 0) begin : g_direct
            assign a_edge[gi] = inj;
        end else begin : g_delay
            logic signed [A_W-1:0] sr_q [gi];
            logic signed [A_W-1:0] sr_d [gi];
            // Shift one stage per advancing cycle; cleared at job start.
            always_comb begin
                sr_d = sr_q;
                if (clr) begin
                    sr_d = '{default: '0};
                end else if (adv) begin
                    sr_d[0] = inj;
                    for (int k = 1; k < gi; k++) begin
                        sr_d[k] = sr_q[k-1];
                    end
                end
            end
            // Delay line registers.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    sr_q <= '{default: '0};
                end else begin
                    sr_q <= sr_d;
                end
            end
            assign a_edge[gi] = sr_q[gi-1];
        end
    end

    // B skew: lane c is delayed c cycles.
    for (gi = 0; gi < COLS; gi++) begin : g_b_skew
        logic signed [B_W-1:0] inj;
        assign inj = accept ? i_b[gi*B_W +: B_W] : '0;
        if (gi == 0) begin : g_direct
            assign b_edge[gi] = inj;
        end else begin : g_delay
            logic signed [B_W-1:0] sr_q [gi];
            logic signed [B_W-1:0] sr_d [gi];
            // Shift one stage per advancing cycle; cleared at job start.
            always_comb begin
                sr_d = sr_q;
                if (clr) begin
                    sr_d = '{default: '0};
                end else if (adv) begin
                    sr_d[0] = inj;
                    for (int k = 1; k < gi; k++) begin
                        sr_d[k] = sr_q[k-1];
                    end
                end
            end
            // Delay line registers.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    sr_q <= '{default: '0};
                end else begin
                    sr_q <= sr_d;
                end
            end
            assign b_edge[gi] = sr_q[gi-1];
        end
    end

    // Processing element grid: multiply-accumulate, pass A east and B south.
    for (gi = 0; gi < ROWS; gi++) begin : g_row
        for (gj = 0; gj < COLS; gj++) begin : g_col
            logic signed [A_W-1:0]   a_in, a_q, a_d;
            logic signed [B_W-1:0]   b_in, b_q, b_d;
            logic signed [ACC_W-1:0] acc_q, acc_d, acc_upd;
            logic signed [PW-1:0]    prod;
            logic signed [SW-1:0]    sum;

            if (gj == 0) begin : g_a_src
                assign a_in = a_edge[gi];
            end else begin : g_a_nbr
                assign a_in = a_fwd[gi][gj-1];
            end
            if (gi == 0) begin : g_b_src
                assign b_in = b_edge[gj];
            end else begin : g_b_nbr
                assign b_in = b_fwd[gi-1][gj];
            end

            // Full-precision signed product and a widened sum that cannot overflow.
            always_comb begin
                prod = $signed({{B_W{a_in[A_W-1]}}, a_in}) * $signed({{A_W{b_in[B_W-1]}}, b_in});
                sum  = $signed({{(SW-ACC_W){acc_q[ACC_W-1]}}, acc_q})
                     + $signed({{(SW-PW){prod[PW-1]}}, prod});
            end

`ifdef SA_SATURATE_EN
            // Clamp to the accumulator range when the upper sum bits are not pure sign.
            always_comb begin
                acc_upd = sum[ACC_W-1:0];
                if (!(&sum[SW-1:ACC_W-1]) && (|sum[SW-1:ACC_W-1])) begin
                    acc_upd = sum[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
                end
            end
`else
            // Two's-complement wrap: keep the low ACC_W bits.
            logic unused_sum_hi;
            assign acc_upd       = sum[ACC_W-1:0];
            assign unused_sum_hi = ^sum[SW-1:ACC_W];
`endif

            // Clear on start, advance while loading/flushing, hold otherwise.
            always_comb begin
                a_d   = a_q;
                b_d   = b_q;
                acc_d = acc_q;
                if (clr) begin
                    a_d   = '0;
                    b_d   = '0;
                    acc_d = '0;
                end else if (adv) begin
                    a_d   = a_in;
                    b_d   = b_in;
                    acc_d = acc_upd;
                end
            end

            // PE forwarding and accumulator registers.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    acc_q <= acc_d;
                end
            end

            assign a_fwd[gi][gj] = a_q;
            assign b_fwd[gi][gj] = b_q;
            assign acc[gi][gj]   = acc_q;
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Testbench for systolic_mm_engine.
// Two instances share every input: a default build (ACC_W=40) and a narrow build (ACC_W=16).
// Expected results come from a plain matrix-product model that honours wrap or saturation.
`timescale 1ns/1ps
module tb_systolic_mm_engine;

    localparam int R    = 4;
    localparam int C    = 4;
    localparam int AW   = 16;
    localparam int BW   = 16;
    localparam int ACCW = 40;
    localparam int NW   = 16;
    localparam int KMAX = 256;
    localparam int KW   = $clog2(KMAX + 1);
`ifdef SA_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic [KW-1:0]     i_k_len;
    logic              i_in_valid;
    logic [R*AW-1:0]   i_a;
    logic [C*BW-1:0]   i_b;
    logic              i_res_ready;

    logic              o_in_ready, o_busy, o_done, o_res_valid;
    logic [C*ACCW-1:0] o_res_data;
    logic [1:0]        o_res_row;
    logic              s_in_ready, s_busy, s_done, s_res_valid;
    logic [C*NW-1:0]   s_res_data;
    logic [1:0]        s_res_row;

    int  checks   = 0;
    int  failures = 0;
    int  cur_k    = 0;
    int  a_mat [KMAX][R];
    int  b_mat [KMAX][C];
    time t_last_acc;
    time t_done;

    always #5 clk = ~clk;

    systolic_mm_engine dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_k_len(i_k_len),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_a(i_a), .i_b(i_b),
        .o_busy(o_busy), .o_done(o_done), .o_res_valid(o_res_valid),
        .i_res_ready(i_res_ready), .o_res_data(o_res_data), .o_res_row(o_res_row)
    );

    systolic_mm_engine #(.ACC_W(NW)) dut16 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_k_len(i_k_len),
        .i_in_valid(i_in_valid), .o_in_ready(s_in_ready), .i_a(i_a), .i_b(i_b),
        .o_busy(s_busy), .o_done(s_done), .o_res_valid(s_res_valid),
        .i_res_ready(i_res_ready), .o_res_data(s_res_data), .o_res_row(s_res_row)
    );

    // C[r][c] = sum_k A[r][k]*B[k][c], folded step by step into a w-bit accumulator.
    function automatic longint model_c(input int r, input int c, input int w, input bit sat);
        longint acc = 0;
        longint lim = longint'(1) << (w - 1);
        for (int k = 0; k < cur_k; k++) begin
            acc += longint'(a_mat[k][r]) * longint'(b_mat[k][c]);
            if (sat) begin
                if (acc > lim - 1) acc = lim - 1;
                else if (acc < -lim) acc = -lim;
            end else begin
                acc = acc & ((lim << 1) - 1);
                if (acc >= lim) acc -= (lim << 1);
            end
        end
        return acc;
    endfunction

    // kind 0: random signed, 1: all 0x7FFF, 2: A = identity, B = 1..16 row-major.
    task automatic gen_data(input int k, input int kind);
        logic signed [15:0] t;
        for (int j = 0; j < k; j++) begin
            for (int r = 0; r < R; r++) begin
                t = 16'($urandom);
                a_mat[j][r] = (kind == 0) ? int'(t) : (kind == 1) ? 32767 : ((r == j) ? 1 : 0);
            end
            for (int c = 0; c < C; c++) begin
                t = 16'($urandom);
                b_mat[j][c] = (kind == 0) ? int'(t) : (kind == 1) ? 32767 : (4 * j + c + 1);
            end
        end
    endtask

    task automatic start_job(input int klen);
        @(negedge clk);
        i_start = 1'b1;
        i_k_len = KW'(klen);
        @(negedge clk);
        i_start = 1'b0;
        i_k_len = '0;
    endtask

    // Feed cur_k beats; mode 0 = back-to-back, 1 = toggling valid, 2 = random valid.
    task automatic feed(input int mode);
        int idx = 0;
        int cyc = 0;
        bit v;
        bit took;
        while (idx < cur_k && cyc < 5000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            i_in_valid = v;
            if (v) begin
                for (int r = 0; r < R; r++) i_a[r*AW +: AW] = AW'(a_mat[idx][r]);
                for (int c = 0; c < C; c++) i_b[c*BW +: BW] = BW'(b_mat[idx][c]);
            end else begin
                i_a = {$urandom(), $urandom()};
                i_b = {$urandom(), $urandom()};
            end
            took = v && o_in_ready;
            @(posedge clk);
            if (took) begin
                idx++;
                t_last_acc = $time;
            end
            cyc++;
            @(negedge clk);
        end
        i_in_valid = 1'b0;
        checks++;
        if (idx != cur_k) begin
            failures++;
            $display("FAIL feed_beats got=%0d exp=%0d", idx, cur_k);
        end
        checks++;
        if (o_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL feed_ready_drop got=%b exp=0 after %0d beats", o_in_ready, cur_k);
        end
    endtask

    // Collect ROWS results; mode 0 = ready high, 1 = random ready, 2 = 5-cycle stall on row 2.
    task automatic drain(input int mode);
        int row = 0;
        int cyc = 0;
        int stall = 0;
        bit rdy;
        logic [C*ACCW-1:0] exp_m;
        logic [C*NW-1:0]   exp_s;
        while (row < R && cyc < 3000) begin
            rdy = 1'b1;
            if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
            if (mode == 2 && o_res_valid && row == 2 && stall < 5) begin
                rdy = 1'b0;
                stall++;
            end
            i_res_ready = rdy;
            i_in_valid  = 1'($urandom_range(0, 1));
            i_a         = {$urandom(), $urandom()};
            i_b         = {$urandom(), $urandom()};
            if (o_res_valid) begin
                for (int c = 0; c < C; c++) begin
                    exp_m[c*ACCW +: ACCW] = ACCW'(model_c(row, c, ACCW, SAT));
                    exp_s[c*NW +: NW]     = NW'(model_c(row, c, NW, SAT));
                end
                checks++;
                if (o_res_row !== 2'(row) || s_res_row !== 2'(row)) begin
                    failures++;
                    $display("FAIL drain_row got=%0d/%0d exp=%0d", o_res_row, s_res_row, row);
                end
                checks++;
                if (o_res_data !== exp_m) begin
                    failures++;
                    $display("FAIL drain_data row=%0d got=%h exp=%h", row, o_res_data, exp_m);
                end
                checks++;
                if (s_res_data !== exp_s) begin
                    failures++;
                    $display("FAIL drain_data16 row=%0d got=%h exp=%h", row, s_res_data, exp_s);
                end
                if (rdy) begin
                    $display("row %0d accepted k=%0d data=%h", row, cur_k, o_res_data);
                    row++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        i_res_ready = 1'b0;
        i_in_valid  = 1'b0;
        checks++;
        if (row != R) begin
            failures++;
            $display("FAIL drain_rows got=%0d exp=%0d", row, R);
        end
        checks++;
        if (o_done !== 1'b1 || s_done !== 1'b1) begin
            failures++;
            $display("FAIL done_pulse got=%b/%b exp=1", o_done, s_done);
        end
        t_done = $time;
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL done_single got done=%b busy=%b exp 0/0", o_done, o_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_start = 1'b1;
        i_k_len = KW'(4);
        i_in_valid = 1'b1;
        i_a = {$urandom(), $urandom()};
        i_b = {$urandom(), $urandom()};
        i_res_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_in_ready, o_busy, o_done, o_res_valid} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {o_in_ready, o_busy, o_done, o_res_valid});
        end
        checks++;
        if (o_res_data !== '0 || o_res_row !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h row=%0d exp=0", o_res_data, o_res_row);
        end
        checks++;
        if ({s_in_ready, s_busy, s_done, s_res_valid} !== 4'b0 || s_res_data !== '0) begin
            failures++;
            $display("FAIL reset_dut16 got=%b %h exp=0", {s_in_ready, s_busy, s_done, s_res_valid}, s_res_data);
        end
        i_start = 1'b0;
        i_k_len = '0;
        i_in_valid = 1'b0;
        i_res_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle got busy=%b exp=0", o_busy);
        end
    endtask

    task automatic test_identity();
        int lat;
        gen_data(4, 2);
        cur_k = 4;
        start_job(4);
        feed(0);
        drain(0);
        // LOAD-exit edge to DONE: ROWS+COLS-1 flush cycles plus one cycle per drained row.
        lat = int'((t_done - t_last_acc) / 10);
        checks++;
        if (lat != (R + C - 1) + R) begin
            failures++;
            $display("FAIL identity_latency got=%0d exp=%0d", lat, (R + C - 1) + R);
        end
    endtask

    task automatic test_gaps();
        gen_data(3, 0);
        cur_k = 3;
        start_job(3);
        feed(0);
        drain(0);
        start_job(3);
        feed(1);
        drain(0);
    endtask

    task automatic test_backpressure();
        gen_data(5, 0);
        cur_k = 5;
        start_job(5);
        feed(2);
        drain(2);
    endtask

    task automatic test_zero_k();
        cur_k = 0;
        start_job(0);
        drain(0);
        gen_data(2, 0);
        cur_k = 2;
        start_job(2);
        i_start = 1'b1;
        i_k_len = KW'(7);
        @(negedge clk);
        i_start = 1'b0;
        i_k_len = '0;
        checks++;
        if (o_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_in_load got ready=%b exp=1", o_in_ready);
        end
        feed(0);
        drain(0);
    endtask

    task automatic test_saturate();
        gen_data(4, 1);
        cur_k = 4;
        start_job(4);
        feed(0);
        drain(0);
    endtask

    task automatic test_reset_mid_flush();
        bit saw_done = 1'b0;
        gen_data(3, 0);
        cur_k = 3;
        start_job(3);
        feed(0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_in_ready, o_busy, o_done, o_res_valid} !== 4'b0 || o_res_data !== '0 || o_res_row !== '0) begin
            failures++;
            $display("FAIL flush_reset got=%b %h exp=0", {o_in_ready, o_busy, o_done, o_res_valid}, o_res_data);
        end
        rst = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (o_done === 1'b1 || s_done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL aborted_done got=1 exp=0");
        end
        gen_data(1, 0);
        cur_k = 1;
        start_job(1);
        feed(0);
        drain(0);
    endtask

    task automatic test_clamp();
        gen_data(KMAX, 0);
        cur_k = KMAX;
        start_job(300);
        feed(0);
        drain(1);
    endtask

    task automatic test_random();
        int k;
        for (int n = 0; n < 6; n++) begin
            k = $urandom_range(1, 12);
            gen_data(k, 0);
            cur_k = k;
            start_job(k);
            feed(2);
            drain(1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        i_start = 1'b0;
        i_k_len = '0;
        i_in_valid = 1'b0;
        i_a = '0;
        i_b = '0;
        i_res_ready = 1'b0;
        test_reset();
        test_identity();
        test_gaps();
        test_backpressure();
        test_zero_k();
        test_saturate();
        test_reset_mid_flush();
        test_clamp();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
